avr_tick_scheduler: RTL and testbench
=====================================

// Module: avr_tick_scheduler
// PURPOSE
//  Sequences tick and pin-sample operations for up to NCORES simulated AVR cores that share one simulator call port.
//  Each core has its own programmable clock divider. Expired cores are queued and served round-robin.
//  Each service is a two-phase transaction: a TICK handshake, then a SAMPLE handshake that latches the returned pin value.
//  Sits between the bench master clock and the simulator-call glue; replaces hand-written per-core always blocks.
// PARAMETERS
//  NCORES   4   number of cores scheduled (1..8)
//  DIVW     16  width of per-core divider reload value
//  PINW     8   width of sampled pin word per core
// PORTS
//  clk          in   1            master clock, all state on posedge
//  rst          in   1            asynchronous reset, active-high
//  enable       in   1            1 = dividers count; 0 = dividers freeze (in-flight transaction completes)
//  cfg_we       in   1            write divider reload for core cfg_idx
//  cfg_idx      in   clog2(NCORES) core index for cfg_we
//  cfg_div      in   DIVW         reload value; period = cfg_div+1 clk cycles
//  op_valid     out  1            operation request to call glue
//  op_kind      out  1            0 = TICK, 1 = SAMPLE
//  op_core      out  clog2(NCORES) core being served
//  op_ready     in   1            glue accepts op when op_valid & op_ready
//  smp_valid    in   1            sampled pin word returned (SAMPLE only)
//  smp_data     in   PINW         pin word
//  pin_state    out  NCORES*PINW  last sampled pin word per core, core i at [i*PINW +: PINW]
//  overrun      out  NCORES       sticky: core expired again while still pending
//  busy         out  1            FSM not in IDLE
// BEHAVIOUR
//  Reset: all dividers = 0, reload = 0, pending = 0, overrun = 0, pin_state = 0, op_valid = 0, FSM = IDLE, rr pointer = 0.
//  Divider i (enable=1): counts down; at 0 reloads and sets pending[i]. cfg_we reloads the counter immediately and clears neither pending nor overrun.
//  Expiry while pending[i]=1 sets overrun[i]. The pending bit stays at 1; at most one queued service per core.
//  Overrun is cleared only by rst.
//  FSM states:
//   - IDLE: if any pending, pick the lowest index >= rr (wrapping), latch it to op_core, go to TICK next cycle.
//   - TICK: op_valid=1, op_kind=0; on op_ready go to SAMPLE.
//   - SAMPLE: op_valid=1, op_kind=1; on op_ready go to WAIT.
//   - WAIT: op_valid=0; on smp_valid write pin_state[op_core], clear pending[op_core], set rr=op_core+1 (wraps), go to IDLE.
//  Latency: expiry -> op_valid(TICK) is >= 2 cycles when the FSM is idle.
//  The pending clear in WAIT and a new expiry of the same core in the same cycle leave pending=1 with no overrun.
//  op_core and op_kind are stable while op_valid & !op_ready.
//  smp_valid outside WAIT is ignored.
//  cfg_idx >= NCORES: the write is ignored.
//  Async rst mid-transaction aborts it: op_valid drops immediately, with no partial pin update.
// CONFIGURATION
//  TICK_SCHED_STATS_EN defined:
//   - adds output svc_count (NCORES*32): per-core completed-service counter, incremented on the WAIT->IDLE transition, wraps at 2^32, reset to 0.
//  Not defined: the port and counters are absent, and the remaining behaviour is identical.
// STRUCTURE
//  Package tick_sched_pkg:
//   - typedef op_kind_t {OP_TICK, OP_SAMPLE}
//   - state enum {ST_IDLE, ST_TICK, ST_SAMPLE, ST_WAIT}
//   - function rr_pick(pending, rr)
//  Sub-module tick_divider: one per core (counter + reload + expire pulse), generated NCORES times.
//  FSM and round-robin live in the top.
// TESTING
//  1. NCORES=2, div0=3, div1=7, op_ready=1, smp_valid 1 cycle after SAMPLE -> core0 served every 4 clk, core1 every 8; pin_state matches smp_data.
//  2. div0=div1=0, both expire every cycle, glue acks in 1 cycle -> strict alternation 0,1,0,1; overrun[1:0]=2'b11 once the backlog forms.
//  3. op_ready held 0 for 5 cycles in TICK -> op_valid, op_kind=0 and op_core stable throughout; SAMPLE follows the cycle after op_ready=1.
//  4. rst asserted in WAIT with smp_valid=1 the same cycle -> pin_state=0, op_valid=0, overrun=0 asynchronously.
//  5. cfg_we to core1 with div=2 mid-count, plus cfg_idx=5 -> core1 expires 3 cycles later; the invalid write changes nothing.
//  6. With TICK_SCHED_STATS_EN: 10 completed core0 services -> svc_count[31:0]=10; core1 count unaffected.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared types and the round-robin pick helper for avr_tick_scheduler.
// Supports up to 8 cores; callers zero-extend their pending vector to 8 bits.
package tick_sched_pkg;

    typedef enum logic {
        OP_TICK   = 1'b0,
        OP_SAMPLE = 1'b1
    } op_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TICK   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // Lowest pending index at or after rr, wrapping modulo ncores.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] pending,
        input logic [2:0] rr,
        input int         ncores
    );
        logic [2:0] pick;
        int         idx;
        pick = '0;
        for (int k = 7; k >= 0; k--) begin
            if (k < ncores) begin
                idx = int'(rr) + k;
                if (idx >= ncores) idx = idx - ncores;
                if (pending[idx]) pick = idx[2:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Per-core programmable divider: down-counter with reload register.
// expire pulses for one cycle while enabled and the counter sits at zero.
module tick_divider
    import tick_sched_pkg::*;
#(
    parameter int DIVW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            load,
    input  logic [DIVW-1:0] load_val,
    output logic            expire
);

    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] reload;

    assign expire = enable && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            reload <= '0;
        end else if (load) begin
            cnt    <= load_val;
            reload <= load_val;
        end else if (enable) begin
            cnt <= expire ? reload : cnt - DIVW'(1);
        end
    end

endmodule

// File: rtl/avr_tick_scheduler.sv
// Round-robin TICK/SAMPLE sequencer for NCORES simulated AVR cores.
// Optional per-core service counters when TICK_SCHED_STATS_EN is defined.
module avr_tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int DIVW   = 16,
    parameter int PINW   = 8,
    localparam int IW    = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   cfg_we,
    input  logic [IW-1:0]          cfg_idx,
    input  logic [DIVW-1:0]        cfg_div,
    output logic                   op_valid,
    output logic                   op_kind,
    output logic [IW-1:0]          op_core,
    input  logic                   op_ready,
    input  logic                   smp_valid,
    input  logic [PINW-1:0]        smp_data,
    output logic [NCORES*PINW-1:0] pin_state,
    output logic [NCORES-1:0]      overrun,
    output logic                   busy
`ifdef TICK_SCHED_STATS_EN
    ,
    output logic [NCORES*32-1:0]   svc_count
`endif
);

    state_t            state;
    logic [NCORES-1:0] expire;
    logic [NCORES-1:0] pending;
    logic [NCORES-1:0] clr;
    logic [IW-1:0]     rr;
    logic [2:0]        pick;
    logic              done;

    assign done     = (state == ST_WAIT) && smp_valid;
    assign pick     = rr_pick(8'(pending), 3'(rr), NCORES);
    assign op_valid = (state == ST_TICK) || (state == ST_SAMPLE);
    assign op_kind  = (state == ST_SAMPLE) ? OP_SAMPLE : OP_TICK;
    assign busy     = (state != ST_IDLE);

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        tick_divider #(
            .DIVW(DIVW)
        ) u_div (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable),
            .load    (cfg_we && (cfg_idx == IW'(i))),
            .load_val(cfg_div),
            .expire  (expire[i])
        );
        assign clr[i] = done && (op_core == IW'(i));
    end

    // A clear and a fresh expiry in the same cycle keep the core queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            overrun   <= '0;
            pin_state <= '0;
        end else begin
            pending <= (pending & ~clr) | expire;
            overrun <= overrun | (expire & pending & ~clr);
            for (int i = 0; i < NCORES; i++) begin
                if (clr[i]) pin_state[i*PINW +: PINW] <= smp_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_core <= '0;
            rr      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        op_core <= IW'(pick);
                        state   <= ST_TICK;
                    end
                end
                ST_TICK: begin
                    if (op_ready) state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (op_ready) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (smp_valid) begin
                        rr    <= (op_core == IW'(NCORES - 1)) ? '0 : op_core + IW'(1);
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TICK_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            svc_count <= '0;
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                if (clr[i]) svc_count[i*32 +: 32] <= svc_count[i*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_avr_tick_scheduler.sv
// Randomised and directed bench for avr_tick_scheduler against a cycle model.
// Builds with or without TICK_SCHED_STATS_EN.
module tb_avr_tick_scheduler;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int PW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            cfg_we;
    logic [IW-1:0]   cfg_idx;
    logic [DW-1:0]   cfg_div;
    logic            op_valid;
    logic            op_kind;
    logic [IW-1:0]   op_core;
    logic            op_ready;
    logic            smp_valid;
    logic [PW-1:0]   smp_data;
    logic [N*PW-1:0] pin_state;
    logic [N-1:0]    overrun;
    logic            busy;
`ifdef TICK_SCHED_STATS_EN
    logic [N*32-1:0] svc_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    avr_tick_scheduler #(
        .NCORES(N),
        .DIVW  (DW),
        .PINW  (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_div  (cfg_div),
        .op_valid (op_valid),
        .op_kind  (op_kind),
        .op_core  (op_core),
        .op_ready (op_ready),
        .smp_valid(smp_valid),
        .smp_data (smp_data),
        .pin_state(pin_state),
        .overrun  (overrun),
        .busy     (busy)
`ifdef TICK_SCHED_STATS_EN
        ,
        .svc_count(svc_count)
`endif
    );

    always #5 clk = ~clk;

    // Model: cycles left before each core expires, its queue flag,
    // and the transaction phase 0=idle 1=tick 2=sample 3=wait.
    int          left [N];
    int          rld  [N];
    bit          pend [N];
    bit          ovr  [N];
    logic [7:0]  pins [N];
    int unsigned svc  [N];
    int          phase;
    int          mcore;
    int          mrr;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            left[i] = 0; rld[i] = 0; pend[i] = 0;
            ovr[i] = 0; pins[i] = '0; svc[i] = 0;
        end
        phase = 0; mcore = 0; mrr = 0;
    endtask

    task automatic model_step();
        bit fin;
        int cur;
        bit fired;
        bit served;
        fin = (phase == 3) && smp_valid;
        cur = mcore;
        case (phase)
            0: begin
                for (int off = N - 1; off >= 0; off--) begin
                    if (pend[(mrr + off) % N]) begin
                        mcore = (mrr + off) % N;
                        phase = 1;
                    end
                end
            end
            1: if (op_ready) phase = 2;
            2: if (op_ready) phase = 3;
            default: if (smp_valid) begin
                mrr = (mcore + 1) % N;
                phase = 0;
            end
        endcase
        for (int i = 0; i < N; i++) begin
            fired  = enable && (left[i] == 0);
            served = fin && (cur == i);
            if (fired && pend[i] && !served) ovr[i] = 1;
            pend[i] = (pend[i] && !served) || fired;
            if (served) begin
                pins[i] = smp_data;
                svc[i]++;
            end
            if (cfg_we && int'(cfg_idx) == i) begin
                rld[i] = int'(cfg_div);
                left[i] = int'(cfg_div);
            end else if (enable) begin
                left[i] = (left[i] == 0) ? rld[i] : left[i] - 1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        logic [N*PW-1:0] ep;
        logic [N-1:0]    eo;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    ep[i*PW +: PW] = pins[i];
                    eo[i] = ovr[i];
                end
                chk("op_valid", 64'(op_valid), 64'(phase == 1 || phase == 2));
                chk("busy", 64'(busy), 64'(phase != 0));
                if (phase == 1 || phase == 2) begin
                    chk("op_kind", 64'(op_kind), 64'(phase == 2));
                    chk("op_core", 64'(op_core), 64'(mcore));
                end
                chk("pin_state", 64'(pin_state), 64'(ep));
                chk("overrun", 64'(overrun), 64'(eo));
`ifdef TICK_SCHED_STATS_EN
                for (int i = 0; i < N; i++)
                    chk("svc_count", 64'(svc_count[i*32 +: 32]), 64'(svc[i]));
`endif
            end
        end
    end

    task automatic cfg(input int idx, input int div);
        cfg_we  = 1'b1;
        cfg_idx = IW'(idx);
        cfg_div = DW'(div);
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    initial begin
        int prev;
        int ticks;
        int bad;
        int waited;
        rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_div = '0; op_ready = 1'b0; smp_valid = 1'b0; smp_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_op_valid", 64'(op_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_pins", 64'(pin_state), 64'd0);

        cfg(0, 3); cfg(1, 7); cfg(2, 200);
        op_ready = 1'b1; smp_valid = 1'b1; smp_data = 8'hA5; enable = 1'b1;
        repeat (5) @(negedge clk);
        chk("first_tick_valid", 64'(op_valid), 64'd1);
        chk("first_tick_kind", 64'(op_kind), 64'd0);
        chk("first_tick_core", 64'(op_core), 64'd0);
        repeat (3) @(negedge clk);
        chk("core0_pin", 64'(pin_state[7:0]), 64'hA5);
        chk("idle_gap", 64'(op_valid), 64'd0);
        @(negedge clk);
        chk("rr_core1", 64'(op_core), 64'd1);
        chk("rr_overrun", 64'(overrun), 64'd0);

        op_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 64'(op_valid), 64'd1);
            chk("stall_kind", 64'(op_kind), 64'd0);
            chk("stall_core", 64'(op_core), 64'd1);
        end
        op_ready = 1'b1;
        @(negedge clk);
        chk("sample_after_stall", 64'(op_kind), 64'd1);
        chk("sample_core", 64'(op_core), 64'd1);

        cfg(0, 0); cfg(1, 0);
        prev = -1; ticks = 0; bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (op_valid && op_kind == 1'b0) begin
                if (int'(op_core) > 1 || int'(op_core) == prev) bad++;
                prev = int'(op_core);
                ticks++;
            end
        end
        chk("alternation_bad", 64'(bad), 64'd0);
        chk("alternation_seen", 64'(ticks >= 8), 64'd1);
        chk("backlog_overrun", 64'(overrun[1:0]), 64'h3);

        smp_valid = 1'b0;
        waited = 0;
        while (phase != 3 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("reach_wait", 64'(phase == 3), 64'd1);
        smp_valid = 1'b1; smp_data = 8'h3C;
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 64'(op_valid), 64'd0);
        chk("async_pins", 64'(pin_state), 64'd0);
        chk("async_overrun", 64'(overrun), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0; enable = 1'b0;

        cfg(0, 200); cfg(1, 100); cfg(2, 200);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_div = 8'd2;
        @(negedge clk);
        cfg_idx = 2'd3; cfg_div = 8'd0;
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reload_not_yet", 64'(op_valid), 64'd0);
        @(negedge clk);
        chk("reload_tick", 64'(op_valid), 64'd1);
        chk("reload_core", 64'(op_core), 64'd1);

        repeat (3000) begin
            @(negedge clk);
            enable    = ($urandom_range(0, 9) != 0);
            cfg_we    = ($urandom_range(0, 19) == 0);
            cfg_idx   = IW'($urandom_range(0, 3));
            cfg_div   = DW'($urandom_range(0, 12));
            op_ready  = ($urandom_range(0, 9) < 7);
            smp_valid = ($urandom_range(0, 1) == 1);
            smp_data  = PW'($urandom);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
